// File: rtl/nonce_sweeper_if.sv
// Hasher-facing bus of nonce_sweeper: header out under valid/ready,
// digest back under a single valid strobe.
interface nonce_sweeper_if #(
    parameter int TEMPLATE_W = 608
);
    logic [TEMPLATE_W+31:0] hdr_out;
    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [255:0]           digest_in;
    logic                   digest_valid;

    modport master (
        output hdr_out,
        output hdr_valid,
        input  hdr_ready,
        input  digest_in,
        input  digest_valid
    );

    modport slave (
        input  hdr_out,
        input  hdr_valid,
        output hdr_ready,
        output digest_in,
        output digest_valid
    );
endinterface

// File: rtl/nonce_sweeper.sv
// Nonce sweeper: walks a nonce range, hands each header to an external double-SHA256
// hasher and stops on the first digest below target. NONCE_LIMIT_EN adds a nonce_end port.
module nonce_sweeper #(
    parameter int TEMPLATE_W = 608
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TEMPLATE_W-1:0] template_in,
    input  logic [31:0]           nonce_start,
`ifdef NONCE_LIMIT_EN
    input  logic [31:0]           nonce_end,
`endif
    input  logic [255:0]          target,
    nonce_sweeper_if.master       hsh,
    output logic                  busy,
    output logic                  found,
    output logic                  exhausted,
    output logic [31:0]           found_nonce,
    output logic [31:0]           attempts
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [TEMPLATE_W-1:0] tmpl_q;
    logic [31:0]           nonce_q;
    logic [31:0]           last_q;
    logic [255:0]          target_q;
    logic [255:0]          digest_q;
    logic                  idle_like;
    logic                  accept;
    logic                  hit;
    logic                  at_last;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign accept    = start && idle_like && !abort;
    assign hit       = digest_q < target_q;
    assign at_last   = nonce_q == last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)            state_d = ISSUE;
            ISSUE:      if (hsh.hdr_ready)    state_d = WAIT;
            WAIT:       if (hsh.digest_valid) state_d = CHECK;
            CHECK:      state_d = (hit || at_last) ? DONE : ISSUE;
            default:    state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Abort only clears the result flags; attempts survives so software can see how far it got.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmpl_q      <= '0;
            nonce_q     <= '0;
            last_q      <= '0;
            target_q    <= '0;
            digest_q    <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            attempts    <= '0;
        end else if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
        end else if (accept) begin
            tmpl_q    <= template_in;
            nonce_q   <= nonce_start;
`ifdef NONCE_LIMIT_EN
            last_q    <= nonce_end;
`else
            last_q    <= nonce_start - 32'd1;
`endif
            target_q  <= target;
            found     <= 1'b0;
            exhausted <= 1'b0;
            attempts  <= '0;
        end else if (state_q == WAIT && hsh.digest_valid) begin
            digest_q <= hsh.digest_in;
        end else if (state_q == CHECK) begin
            if (attempts != 32'hFFFF_FFFF) begin
                attempts <= attempts + 32'd1;
            end
            if (hit) begin
                found       <= 1'b1;
                found_nonce <= nonce_q;
            end else if (at_last) begin
                exhausted <= 1'b1;
            end else begin
                nonce_q <= nonce_q + 32'd1;
            end
        end
    end

    // The nonce sits little-endian in the last header word, as the hasher expects raw header bytes.
    assign hsh.hdr_out   = {tmpl_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    assign hsh.hdr_valid = (state_q == ISSUE);
    assign busy          = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
endmodule

// File: tb/tb_nonce_sweeper.sv
// Scoreboard bench for nonce_sweeper: directed sweeps push expected headers and results,
// a negedge monitor compares them as the DUT presents them. Define NONCE_LIMIT_EN for range tests.
module tb_nonce_sweeper;
    localparam int TW = 608;

    typedef struct {
        logic        found;
        logic        exh;
        logic [31:0] fnonce;
        logic [31:0] att;
        int          cycles;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] template_in = '0;
    logic [31:0]   nonce_start = '0;
`ifdef NONCE_LIMIT_EN
    logic [31:0]   nonce_end = '0;
`endif
    logic [255:0]  target = '0;
    logic          busy;
    logic          found;
    logic          exhausted;
    logic [31:0]   found_nonce;
    logic [31:0]   attempts;

    nonce_sweeper_if #(.TEMPLATE_W(TW)) bus ();

    nonce_sweeper #(.TEMPLATE_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .template_in (template_in),
        .nonce_start (nonce_start),
`ifdef NONCE_LIMIT_EN
        .nonce_end   (nonce_end),
`endif
        .target      (target),
        .hsh         (bus),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_nonce (found_nonce),
        .attempts    (attempts)
    );

    int             checks = 0;
    int             errors = 0;
    logic [TW+31:0] exp_hdr[$];
    res_t           exp_res[$];
    logic [255:0]   digest_feed[$];
    int             stall_left = 0;
    bit             force_digest = 1'b0;
    bit             hs_seen = 1'b0;
    bit             prev_busy = 1'b0;
    int             busy_cyc = 0;
    logic [TW-1:0]  tA, tB, tC, tD, tE;

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] mkTmpl(input logic [7:0] seed);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TW / 32; i++) begin
            t[i*32 +: 32] = {seed, 8'h5A, 8'(i), ~seed};
        end
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [TW+31:0] act, input logic [TW+31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [TW-1:0] tmpl, input logic [31:0] nstart, input logic [255:0] tgt);
        @(posedge clk); #1;
        template_in = tmpl;
        nonce_start = nstart;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        template_in = ~tmpl;
        nonce_start = ~nstart;
        target      = '0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {639'd0, busy}, '0);
    endtask

    task automatic waitHandshake(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.hdr_valid && bus.hdr_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {639'd0, bus.hdr_valid && bus.hdr_ready}, 640'd1);
    endtask

    task automatic pulseAbort();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    // Hasher model: stalls hdr_ready on request and returns one digest the cycle after each handshake.
    initial begin
        bus.hdr_ready    = 1'b0;
        bus.digest_valid = 1'b0;
        bus.digest_in    = '0;
        forever begin
            @(posedge clk); #1;
            bus.digest_valid = 1'b0;
            if (force_digest) begin
                bus.digest_valid = 1'b1;
                bus.digest_in    = '0;
                force_digest     = 1'b0;
            end else if (hs_seen) begin
                bus.digest_valid = 1'b1;
                if (digest_feed.size() > 0) bus.digest_in = digest_feed.pop_front();
                else bus.digest_in = '1;
                hs_seen = 1'b0;
            end
            if (bus.hdr_valid && stall_left > 0) begin
                bus.hdr_ready = 1'b0;
                stall_left--;
            end else begin
                bus.hdr_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.hdr_valid) begin
            if (exp_hdr.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL hdr_unexpected got %h expected none", bus.hdr_out[31:0]);
            end else begin
                checkOutput("hdr_out", bus.hdr_out, exp_hdr[0]);
                if (bus.hdr_ready) begin
                    void'(exp_hdr.pop_front());
                    hs_seen = 1'b1;
                end
            end
        end
        if (busy) busy_cyc++;
        if (prev_busy && !busy) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL res_unexpected got found=%0b exhausted=%0b expected none", found, exhausted);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                checkOutput("found", {639'd0, found}, {639'd0, r.found});
                checkOutput("exhausted", {639'd0, exhausted}, {639'd0, r.exh});
                checkOutput("found_nonce", {608'd0, found_nonce}, {608'd0, r.fnonce});
                checkOutput("attempts", {608'd0, attempts}, {608'd0, r.att});
                if (r.cycles >= 0) checkOutput("busy_cycles", {608'd0, 32'(busy_cyc)}, {608'd0, 32'(r.cycles)});
            end
            busy_cyc = 0;
        end
        prev_busy = busy;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tA = mkTmpl(8'h11);
        tB = mkTmpl(8'h22);
        tC = mkTmpl(8'h33);
        tD = mkTmpl(8'h44);
        tE = mkTmpl(8'h55);

        #12;
        checkOutput("rst_busy", {639'd0, busy}, '0);
        checkOutput("rst_hdr_valid", {639'd0, bus.hdr_valid}, '0);
        checkOutput("rst_found", {639'd0, found}, '0);
        checkOutput("rst_exhausted", {639'd0, exhausted}, '0);
        checkOutput("rst_found_nonce", {608'd0, found_nonce}, '0);
        checkOutput("rst_attempts", {608'd0, attempts}, '0);
        checkOutput("rst_hdr_out", bus.hdr_out, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] sweep finds a hit on the third nonce");
        exp_hdr.push_back({tA, 32'h1000_0000});
        exp_hdr.push_back({tA, 32'h1100_0000});
        exp_hdr.push_back({tA, 32'h1200_0000});
        digest_feed.push_back('1);
        digest_feed.push_back('1);
        digest_feed.push_back(256'd1);
        exp_res.push_back('{1'b1, 1'b0, 32'h0000_0012, 32'd3, 9});
        applyStimulus(tA, 32'h0000_0010, 256'hFFFF << 208);
        repeat (3) @(posedge clk);
        #1;
        template_in = tB;
        nonce_start = 32'h0000_0999;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle("t1_idle");

        $display("[TB] stalled handshake with a stray digest in ISSUE");
        exp_hdr.push_back({tB, 32'h7856_3412});
        digest_feed.push_back(256'd5);
        exp_res.push_back('{1'b1, 1'b0, 32'h1234_5678, 32'd1, 8});
        stall_left = 5;
        applyStimulus(tB, 32'h1234_5678, 256'd1 << 200);
        @(negedge clk);
        force_digest = 1'b1;
        waitIdle("t2_idle");
        pulseAbort();
        checkOutput("done_abort_found", {639'd0, found}, '0);
        checkOutput("done_abort_attempts", {608'd0, attempts}, 640'd1);
        checkOutput("done_abort_busy", {639'd0, busy}, '0);

        $display("[TB] abort in WAIT against a concurrent digest");
        exp_hdr.push_back({tC, 32'h0001_0000});
        exp_res.push_back('{1'b0, 1'b0, 32'h1234_5678, 32'd0, 2});
        applyStimulus(tC, 32'h0000_0100, 256'h1_0000);
        waitHandshake("t3_handshake");
        pulseAbort();
        checkOutput("wait_abort_busy", {639'd0, busy}, '0);
        checkOutput("wait_abort_found", {639'd0, found}, '0);
        checkOutput("wait_abort_hdr_valid", {639'd0, bus.hdr_valid}, '0);
        @(negedge clk);
        exp_hdr.push_back({tC, 32'h0002_0000});
        digest_feed.push_back('0);
        exp_res.push_back('{1'b1, 1'b0, 32'h0000_0200, 32'd1, 3});
        applyStimulus(tC, 32'h0000_0200, 256'h1_0000);
        waitIdle("t3_idle");

`ifdef NONCE_LIMIT_EN
        $display("[TB] bounded sweep wrapping through zero");
        exp_hdr.push_back({tD, 32'hFEFF_FFFF});
        exp_hdr.push_back({tD, 32'hFFFF_FFFF});
        exp_hdr.push_back({tD, 32'h0000_0000});
        exp_hdr.push_back({tD, 32'h0100_0000});
        exp_res.push_back('{1'b0, 1'b1, 32'h0000_0200, 32'd4, 12});
        nonce_end = 32'h0000_0001;
        applyStimulus(tD, 32'hFFFF_FFFE, 256'h1_0000);
        waitIdle("t4_idle");

        $display("[TB] hit on the last nonce");
        exp_hdr.push_back({tD, 32'h0500_0000});
        exp_hdr.push_back({tD, 32'h0600_0000});
        digest_feed.push_back('1);
        digest_feed.push_back('0);
        exp_res.push_back('{1'b1, 1'b0, 32'h0000_0006, 32'd2, 6});
        nonce_end = 32'h0000_0006;
        applyStimulus(tD, 32'h0000_0005, 256'h1_0000);
        waitIdle("t5_idle");
`endif

        $display("[TB] asynchronous reset during CHECK");
        exp_hdr.push_back({tE, 32'h4000_0000});
        exp_res.push_back('{1'b0, 1'b0, 32'h0000_0000, 32'd0, -1});
        applyStimulus(tE, 32'h0000_0040, 256'h1_0000);
        waitHandshake("t6_handshake");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {639'd0, busy}, '0);
        checkOutput("arst_hdr_valid", {639'd0, bus.hdr_valid}, '0);
        checkOutput("arst_found_nonce", {608'd0, found_nonce}, '0);
        checkOutput("arst_attempts", {608'd0, attempts}, '0);
        checkOutput("arst_hdr_out", bus.hdr_out, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        force_digest = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_busy", {639'd0, busy}, '0);
        checkOutput("post_rst_attempts", {608'd0, attempts}, '0);
        checkOutput("post_rst_found", {639'd0, found}, '0);

        checkOutput("hdr_queue_empty", {608'd0, 32'(exp_hdr.size())}, '0);
        checkOutput("res_queue_empty", {608'd0, 32'(exp_res.size())}, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_sweeper.md
NONCE_SWEEPER -- requirements
Module: nonce_sweeper

Interface
REQ-001 SHALL have parameter TEMPLATE_W, default 608, meaning width of the header template (first 76 bytes of the 80-byte header).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse that launches a sweep.
REQ-005 SHALL have port abort  input  1  terminates any sweep in progress.
REQ-006 SHALL have port template_in  input  608  header bits 639:32, captured on an accepted start.
REQ-007 SHALL have port nonce_start  input  32  first nonce, captured on an accepted start.
REQ-008 SHALL have port target  input  256  difficulty target, captured on an accepted start.
REQ-009 SHALL have port hdr_out  output  640  header presented to the downstream hasher.
REQ-010 SHALL have port hdr_valid  output  1  hdr_out holds a valid header.
REQ-011 SHALL have port hdr_ready  input  1  hasher accepts hdr_out.
REQ-012 SHALL have port digest_in  input  256  double-SHA256 result from the hasher, MSB-first.
REQ-013 SHALL have port digest_valid  input  1  digest_in is valid this cycle.
REQ-014 SHALL have port busy, found, exhausted  output  1 each  status flags.
REQ-015 SHALL have port found_nonce  output  32  nonce that met the target.
REQ-016 SHALL have port attempts  output  32  digests checked in the current sweep; saturates at 0xFFFFFFFF.

Function
REQ-017 SHALL use the states IDLE, ISSUE, WAIT, CHECK and DONE.
REQ-018 SHALL, in IDLE or DONE, accept start by capturing template, nonce_start and target, clearing found, exhausted and attempts, and moving to ISSUE.
REQ-019 SHALL ignore start in ISSUE, WAIT and CHECK.
REQ-020 SHALL drive hdr_out as {template, byte-swapped nonce}, with hdr_out[31:0] = {n[7:0], n[15:8], n[23:16], n[31:24]}.
REQ-021 SHALL assert hdr_valid only in ISSUE, holding hdr_out stable until a cycle with hdr_valid and hdr_ready both high, and then move to WAIT.
REQ-022 SHALL ignore digest_valid outside WAIT; in WAIT, digest_valid SHALL register digest_in and move to CHECK.
REQ-023 SHALL, in CHECK, increment attempts (saturating) and compare digest < target as unsigned 256-bit values; equality is a miss.
REQ-024 SHALL, on a hit, set found, load found_nonce with the current nonce and move to DONE.
REQ-025 SHALL, on a miss at the last nonce, set exhausted and move to DONE; on any other miss it SHALL add 1 to nonce modulo 2^32 and return to ISSUE.
REQ-026 SHALL give a minimum of 3 cycles per nonce: ISSUE to WAIT to CHECK, with hdr_ready and digest_valid arriving immediately.
REQ-027 SHALL assert busy in ISSUE, WAIT and CHECK, and deassert it in IDLE and DONE.
REQ-028 SHALL, on abort in any state, go to IDLE on the next edge with hdr_valid low, found and exhausted cleared, and attempts retained; abort SHALL win over a simultaneous start or digest_valid.
REQ-029 SHALL give priority to found over exhausted when a hit occurs on the last nonce.

Reset
REQ-030 SHALL, while rst_n is low, force state to IDLE and hold hdr_valid, busy, found and exhausted at 0, found_nonce at 0, attempts at 0, hdr_out at 0 and the internal nonce at 0.
REQ-031 SHALL treat reset asserted mid-sweep as an abandoned sweep; a digest arriving afterwards SHALL be ignored.

Configuration
REQ-032 SHALL compile in a nonce_end input (32 bits, captured on start) when NONCE_LIMIT_EN is defined; the last nonce is then nonce_end, reached after wrapping through 0xFFFFFFFF when nonce_start > nonce_end.
REQ-033 SHALL omit the nonce_end port when NONCE_LIMIT_EN is undefined; the last nonce is then nonce_start - 1 (mod 2^32), giving a full 2^32 sweep.

Verification
REQ-034 SHALL cover: start with nonce_start=0x00000010, digests all 0xFF..FF on the first two attempts and 0x00..01 on the third, target=0x00000000FFFF<<208 -> found=1, found_nonce=0x00000012, attempts=3.
REQ-035 SHALL cover: nonce 0x12345678 in ISSUE -> hdr_out[31:0]=0x78563412, hdr_out[639:32]=template.
REQ-036 SHALL cover: hdr_ready held low for 5 cycles -> hdr_valid stays high and hdr_out is unchanged every cycle; a digest_valid pulse during ISSUE is ignored.
REQ-037 SHALL cover, with NONCE_LIMIT_EN: nonce_start=0xFFFFFFFE, nonce_end=0x00000001, all misses -> 4 headers issued (FFFFFFFE, FFFFFFFF, 0, 1), exhausted=1, found=0.
REQ-038 SHALL cover: abort raised in WAIT with a concurrent digest_valid -> IDLE next cycle, busy=0, found=0, and a subsequent start restarts from the newly sampled nonce_start.
REQ-039 SHALL cover: rst_n dropped asynchronously mid-CHECK -> all outputs 0 without waiting for a clock edge.
